// File: rtl/mux_serializer_pkg.sv
// Shared widths, FSM state type and bit-order helpers for the 8-bit serializer.
package mux_serializer_pkg;

   localparam int WORD_W = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic logic [SEL_W-1:0] first_sel(input bit msb_first);
      return msb_first ? 3'd7 : 3'd0;
   endfunction

   function automatic logic [SEL_W-1:0] last_sel(input bit msb_first);
      return msb_first ? 3'd0 : 3'd7;
   endfunction

endpackage

// File: rtl/mux_serializer_mux.sv
// Existing 8-to-1 bit multiplexer: dout = din[s].
module mux_8to1
   import mux_serializer_pkg::*;
(
   input  logic [WORD_W-1:0] din,
   input  logic [SEL_W-1:0]  s,
   output logic              dout
);

   assign dout = din[s];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial sequencer: holds one word and walks a select counter
// through mux_8to1, presenting each bit on a valid/ready serial interface.
module mux_serializer
   import mux_serializer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              ser_ready,
   output logic              ser_valid,
   output logic              ser_data,
   output logic              ser_last,
   output logic [SEL_W-1:0]  sel,
   output logic              done
);

   localparam logic [SEL_W-1:0] FIRST_SEL = first_sel(MSB_FIRST);
   localparam logic [SEL_W-1:0] LAST_SEL  = last_sel(MSB_FIRST);

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  hold_q, hold_d;
   logic [SEL_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               mux_bit;
   logic               at_last;

   mux_8to1 u_mux (
      .din  (hold_q),
      .s    (cnt_q),
      .dout (mux_bit)
   );

   assign at_last = (cnt_q == LAST_SEL);
   assign done    = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      ser_last  = 1'b0;
      sel       = '0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_d  = in_data;
               cnt_d   = FIRST_SEL;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            sel       = cnt_q;
            ser_data  = mux_bit;
            ser_last  = at_last;
            // Only the final-bit transfer may take a new word, so hold never changes mid-word.
            in_ready  = at_last & ser_ready;
            if (ser_ready) begin
               if (at_last) begin
                  done_d = 1'b1;
                  if (in_valid) begin
                     hold_d = in_data;
                     cnt_d  = FIRST_SEL;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (MSB_FIRST) begin
                  cnt_d = cnt_q - 3'd1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: one LSB-first and one MSB-first instance.
module tb_mux_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       a_in_valid = 1'b0, a_ser_ready = 1'b1;
   logic [7:0] a_in_data = 8'h00;
   logic       a_in_ready, a_ser_valid, a_ser_data, a_ser_last, a_done;
   logic [2:0] a_sel;

   logic       b_in_valid = 1'b0, b_ser_ready = 1'b1;
   logic [7:0] b_in_data = 8'h00;
   logic       b_in_ready, b_ser_valid, b_ser_data, b_ser_last, b_done;
   logic [2:0] b_sel;

   int checks = 0;
   int failures = 0;

   int exp19[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
   int expE6[8] = '{0, 1, 1, 0, 0, 1, 1, 1};
   int expA5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

   always #5 clk = ~clk;

   mux_serializer #(.MSB_FIRST(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .ser_ready(a_ser_ready), .ser_valid(a_ser_valid),
      .ser_data(a_ser_data), .ser_last(a_ser_last), .sel(a_sel), .done(a_done)
   );

   mux_serializer #(.MSB_FIRST(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .ser_ready(b_ser_ready), .ser_valid(b_ser_valid),
      .ser_data(b_ser_data), .ser_last(b_ser_last), .sel(b_sel), .done(b_done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk_a_idle(input string tag);
      chk({tag, ".in_ready"}, int'(a_in_ready), 1);
      chk({tag, ".ser_valid"}, int'(a_ser_valid), 0);
      chk({tag, ".ser_data"}, int'(a_ser_data), 0);
      chk({tag, ".ser_last"}, int'(a_ser_last), 0);
      chk({tag, ".sel"}, int'(a_sel), 0);
   endtask

   initial begin
      // Reset state
      #3;
      chk_a_idle("rst_a");
      chk("rst_a.done", int'(a_done), 0);
      chk("rst_b.in_ready", int'(b_in_ready), 1);
      chk("rst_b.ser_valid", int'(b_ser_valid), 0);
      chk("rst_b.sel", int'(b_sel), 0);
      tick; tick;
      rst_n = 1'b1;
      tick;

      // LSB-first 8'h19
      a_in_valid = 1'b1; a_in_data = 8'h19;
      #1 chk("lsb.accept_ready", int'(a_in_ready), 1);
      tick;
      a_in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         $display("lsb bit %0d: sel=%0d data=%0d last=%0d", i, a_sel, a_ser_data, a_ser_last);
         chk($sformatf("lsb.valid[%0d]", i), int'(a_ser_valid), 1);
         chk($sformatf("lsb.data[%0d]", i), int'(a_ser_data), exp19[i]);
         chk($sformatf("lsb.sel[%0d]", i), int'(a_sel), i);
         chk($sformatf("lsb.last[%0d]", i), int'(a_ser_last), (i == 7) ? 1 : 0);
         chk($sformatf("lsb.done[%0d]", i), int'(a_done), 0);
         tick;
      end
      #1;
      chk("lsb.done_pulse", int'(a_done), 1);
      chk_a_idle("lsb.after");
      tick;
      #1 chk("lsb.done_clear", int'(a_done), 0);

      // MSB-first 8'hA5
      b_in_valid = 1'b1; b_in_data = 8'hA5;
      tick;
      b_in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         $display("msb bit %0d: sel=%0d data=%0d last=%0d", i, b_sel, b_ser_data, b_ser_last);
         chk($sformatf("msb.data[%0d]", i), int'(b_ser_data), expA5[i]);
         chk($sformatf("msb.sel[%0d]", i), int'(b_sel), 7 - i);
         chk($sformatf("msb.last[%0d]", i), int'(b_ser_last), (i == 7) ? 1 : 0);
         tick;
      end
      #1;
      chk("msb.done_pulse", int'(b_done), 1);
      chk("msb.idle_valid", int'(b_ser_valid), 0);
      tick;

      // Backpressure at sel=2, in_data churn ignored
      a_in_valid = 1'b1; a_in_data = 8'h19;
      tick;
      a_in_valid = 1'b0;
      tick; tick;
      for (int i = 0; i < 3; i++) begin
         a_ser_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hFF - 8'(i);
         #1;
         $display("bp stall %0d: sel=%0d data=%0d valid=%0d", i, a_sel, a_ser_data, a_ser_valid);
         chk($sformatf("bp.sel[%0d]", i), int'(a_sel), 2);
         chk($sformatf("bp.data[%0d]", i), int'(a_ser_data), 0);
         chk($sformatf("bp.valid[%0d]", i), int'(a_ser_valid), 1);
         chk($sformatf("bp.in_ready[%0d]", i), int'(a_in_ready), 0);
         tick;
      end
      a_ser_ready = 1'b1; a_in_valid = 1'b0;
      for (int i = 2; i < 8; i++) begin
         #1;
         chk($sformatf("bp.resume_data[%0d]", i), int'(a_ser_data), exp19[i]);
         chk($sformatf("bp.resume_sel[%0d]", i), int'(a_sel), i);
         tick;
      end
      #1 chk("bp.done_pulse", int'(a_done), 1);
      tick;

      // Back-to-back 8'h19 then 8'hE6
      a_in_valid = 1'b1; a_in_data = 8'h19;
      tick;
      for (int k = 0; k < 16; k++) begin
         if (k == 0) a_in_data = 8'hE6;
         if (k == 8) a_in_valid = 1'b0;
         #1;
         $display("b2b bit %0d: sel=%0d data=%0d done=%0d", k, a_sel, a_ser_data, a_done);
         chk($sformatf("b2b.valid[%0d]", k), int'(a_ser_valid), 1);
         chk($sformatf("b2b.data[%0d]", k), int'(a_ser_data), (k < 8) ? exp19[k] : expE6[k-8]);
         chk($sformatf("b2b.sel[%0d]", k), int'(a_sel), k % 8);
         chk($sformatf("b2b.last[%0d]", k), int'(a_ser_last), (k % 8 == 7) ? 1 : 0);
         chk($sformatf("b2b.in_ready[%0d]", k), int'(a_in_ready), (k % 8 == 7) ? 1 : 0);
         chk($sformatf("b2b.done[%0d]", k), int'(a_done), (k == 8) ? 1 : 0);
         tick;
      end
      #1;
      chk("b2b.done2", int'(a_done), 1);
      chk("b2b.end_valid", int'(a_ser_valid), 0);
      tick;

      // Mid-word reset at sel=4
      a_in_valid = 1'b1; a_in_data = 8'hFF;
      tick;
      a_in_valid = 1'b0;
      tick; tick; tick; tick;
      #1;
      chk("mid.sel_before", int'(a_sel), 4);
      chk("mid.data_before", int'(a_ser_data), 1);
      rst_n = 1'b0;
      #1;
      $display("mid-word reset: sel=%0d valid=%0d", a_sel, a_ser_valid);
      chk_a_idle("mid.rst");
      chk("mid.rst_done", int'(a_done), 0);
      tick;
      rst_n = 1'b1;
      tick;
      #1 chk("mid.no_done", int'(a_done), 0);
      a_in_valid = 1'b1; a_in_data = 8'h01;
      tick;
      a_in_valid = 1'b0;
      #1;
      chk("mid.next_sel", int'(a_sel), 0);
      chk("mid.next_data", int'(a_ser_data), 1);
      chk("mid.next_valid", int'(a_ser_valid), 1);
      tick;
      #1 chk("mid.next_bit1", int'(a_ser_data), 0);
      for (int i = 1; i < 8; i++) tick;
      #1 chk("mid.next_done", int'(a_done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial sequencer that sits directly upstream of mux_8to1.
- Accepts an 8-bit word over a valid/ready handshake and holds it in a register.
- Steps a 3-bit select counter through the bit positions to serialise the held word through a mux_8to1 instance.
- Presents each bit on a valid/ready serial output with backpressure, a last-bit flag and a completion pulse.

Parameters:
- MSB_FIRST, 0, 0: bit order din[0]..din[7]; 1: bit order din[7]..din[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  8  parallel word; sampled only when in_valid & in_ready.
- ser_ready  input  1  downstream accepts the current serial bit.
- ser_valid  output  1  ser_data carries a valid bit.
- ser_data  output  1  current serial bit, equal to hold[sel] via mux_8to1.
- ser_last  output  1  current bit is the final bit of the word.
- sel  output  3  current select value driving the mux; for debug and visibility.
- done  output  1  one-cycle pulse after the final bit transfers.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, hold=8'h00, cnt=0.
  - in_ready=1, ser_valid=0, ser_data=0, ser_last=0, sel=0, done=0.
- States: IDLE and SHIFT.
- Bit transfer: occurs when ser_valid & ser_ready at a rising edge.
- Final bit: cnt==7 when MSB_FIRST=0; cnt==0 when MSB_FIRST=1.
- IDLE:
  - in_ready=1, ser_valid=0, ser_data forced to 0, ser_last=0.
  - On in_valid: hold<=in_data, cnt<=(MSB_FIRST?7:0), go to SHIFT.
- SHIFT:
  - ser_valid=1, sel=cnt, ser_data=hold[cnt]; ser_data is combinational from the registered hold and cnt.
  - ser_last=1 while cnt is at the final bit.
  - On a non-final transfer: cnt<=cnt+1 (MSB_FIRST=0) or cnt<=cnt-1 (MSB_FIRST=1).
  - ser_ready=0: cnt, sel, ser_data and ser_last hold; ser_valid stays 1, never drops mid-word.
  - in_ready = ser_last & ser_ready, so the block is ready only during the final-bit transfer cycle.
  - Final transfer with a new word accepted in the same cycle: reload hold and cnt, stay in SHIFT, no bubble.
  - Final transfer without a new word: go to IDLE.
- done: registered; high exactly one cycle after each final-bit transfer. This includes back-to-back words.
- Latency and throughput:
  - A word accepted at edge N has its first bit valid in cycle N+1.
  - Minimum 8 cycles per word; sustained 1 bit/cycle with back-to-back words.
- in_data is ignored whenever in_ready=0; hold never changes mid-word.
- Reset mid-word: word aborted, no done pulse; the next accepted word starts from its first bit.
- Widths:
  - cnt is 3 bits; it never wraps in normal operation because the final bit exits or reloads.
  - The default state maps to IDLE.

Decomposition:
- Shared package:
  - WORD_W=8, SEL_W=3.
  - State enum {IDLE, SHIFT}.
  - FIRST_SEL / LAST_SEL constants derived from MSB_FIRST.
- Sub-module: one existing mux_8to1 instance with din=hold, s=cnt, dout=internal bit.
  - Output gating (ser_data forced to 0 in IDLE) lives in mux_serializer.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation -> in_ready=1, ser_valid=0, ser_data=0, ser_last=0, sel=0, done=0.
- LSB-first, MSB_FIRST=0, ser_ready=1: load 8'h19 -> bits 1,0,0,1,1,0,0,0 on cycles 1..8; sel 0..7; ser_last only on cycle 8; done on cycle 9.
- MSB-first, MSB_FIRST=1: load 8'hA5 -> bits 1,0,1,0,0,1,0,1; sel 7..0.
- Backpressure: load 8'h19, drop ser_ready for 3 cycles at sel=2 -> sel=2, ser_data=0, ser_valid=1 held stable, then resume; in_data changes during the word have no effect.
- Back-to-back: 8'h19 then 8'hE6 offered with in_valid held high -> 16 contiguous valid bits, no IDLE cycle, done pulses on cycles 9 and 17.
- Mid-word reset: load 8'hFF, assert rst_n=0 at sel=4 -> immediate IDLE, no done; next load 8'h01 starts at sel=0 with bit 1.
